pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have a single clock and an asynchronous active-high reset, with ports clk and rst.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_next  input  16  next PC from the branch/PC-control stage, valid while instr_valid=1.
REQ-005 instr_ready  input  1  consumer accepts the current instruction this cycle.
REQ-006 imem_rdy  input  1  instruction memory has data on imem_data this cycle.
REQ-007 imem_data  input  16  instruction word from memory.
REQ-008 imem_req  output  1  read request to instruction memory.
REQ-009 imem_addr  output  16  read address; equals pc_curr.
REQ-010 pc_curr  output  16  current PC; feeds the PC-control stage PC input.
REQ-011 instr  output  16  latched instruction; [15:12] opcode, [11:9] condition, [8:0] offset.
REQ-012 instr_valid  output  1  instr holds a fetched, not-yet-accepted instruction.
REQ-013 halted  output  1  HLT instruction retired; fetch stopped.
REQ-014 instr_count  output  16  count of accepted non-HLT instructions.

Function
REQ-015 SHALL implement states IDLE, FETCH, VALID, HALT.
REQ-016 IDLE: all handshake outputs 0; SHALL move to FETCH on the next edge unconditionally.
REQ-017 FETCH: imem_req=1, imem_addr=pc_curr. On imem_rdy=1, SHALL latch imem_data into instr and move to VALID. Otherwise SHALL remain in FETCH with the address held stable.
REQ-018 imem_rdy in the same cycle as imem_req SHALL be accepted (zero-wait memory). Minimum fetch-to-valid latency is 1 cycle.
REQ-019 VALID: instr_valid=1, imem_req=0. instr and pc_curr SHALL be held stable until instr_ready=1.
REQ-020 VALID with instr_ready=1 and instr[15:12]!=4'hF: pc_curr <= {pc_next[15:1],1'b0}, instr_count += 1 (wraps 16'hFFFF->0), and the state SHALL move to FETCH.
REQ-021 VALID with instr_ready=1 and instr[15:12]==4'hF (HLT): pc_curr and instr_count unchanged, and the state SHALL move to HALT.
REQ-022 HALT: halted=1, imem_req=0, instr_valid=0. SHALL remain in HALT until reset; imem_rdy and instr_ready are ignored.
REQ-023 imem_rdy outside FETCH and instr_ready outside VALID SHALL have no effect.
REQ-024 pc_next[0] SHALL be discarded; pc_curr[0] is always 0.
REQ-025 PC wrap-around (pc_next=16'h0000 after 16'hFFFE) SHALL be taken as-is with no special handling.
REQ-026 instr_valid and imem_req SHALL never be 1 in the same cycle.

Reset
REQ-027 While rst=1: state=IDLE, pc_curr=16'h0000, instr=16'h0000, instr_count=16'h0000, instr_valid=0, imem_req=0, halted=0.
REQ-028 Reset asserted mid-FETCH or mid-VALID SHALL abort immediately. Any memory response arriving during reset SHALL be dropped.
REQ-029 The first imem_req SHALL occur in the second cycle after rst deasserts, with IDLE occupying the first cycle.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the fetch state enum, OPC_HLT=4'hF, and PC_RESET=16'h0000.
REQ-031 The PC SHALL be held in one sub-module pc_reg: a 16-bit register with write enable and async reset to PC_RESET.
REQ-032 State register, instr latch and instr_count SHALL be in pc_fetch. No arithmetic adders beyond the instr_count increment.

Verification
REQ-033 Reset release, imem_rdy tied 1, imem_data=16'h1234: imem_req=1 at cycle 2, addr 16'h0000; instr_valid=1 at cycle 3 with instr=16'h1234.
REQ-034 Wait states: imem_rdy low for 3 cycles in FETCH -> imem_addr stable for 4 cycles, instr_valid rises the cycle after imem_rdy=1.
REQ-035 Backpressure: instr_ready low 5 cycles in VALID, pc_next toggling -> pc_curr/instr unchanged. On accept with pc_next=16'h0041, pc_curr=16'h0040 and instr_count=1.
REQ-036 HLT: imem_data=16'hF000 accepted -> halted=1, pc_curr unchanged, instr_count unchanged, no further imem_req for 20 cycles.
REQ-037 Wrap: pc_curr=16'hFFFE, accept with pc_next=16'h0000 -> next imem_addr=16'h0000. instr_count preset to 16'hFFFF wraps to 16'h0000.
REQ-038 Reset mid-FETCH with imem_rdy=1 coincident -> all outputs at reset values, instr=16'h0000, refetch from 16'h0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, HLT opcode and PC reset value.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [3:0]  OPC_HLT  = 4'hF;
    localparam logic [15:0] PC_RESET = 16'h0000;

    // True when the instruction word carries the HLT opcode in [15:12].
    function automatic logic is_hlt(input logic [15:0] word);
        return word[15:12] == OPC_HLT;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: 16-bit, write-enabled, async reset to PC_RESET.
module pc_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Load a new PC only when the fetch FSM retires a non-HLT instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= PC_RESET;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: requests the word at pc_curr, holds it until the
// consumer accepts, then advances the PC from pc_next or stops on HLT.
//
// Handshakes: the memory side completes in any FETCH cycle where imem_req=1
// and imem_rdy=1 (zero-wait allowed); the consumer side completes in any VALID
// cycle where instr_valid=1 and instr_ready=1. imem_req and instr_valid are
// decoded from mutually exclusive states, so they are never high together.
module pc_fetch
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_next,
    input  logic        instr_ready,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc_curr,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic [15:0] instr_count
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         pc_we;
    logic         latch_en;
    logic         count_en;
    logic [15:0]  pc_d;

    // PC is always halfword aligned; the low bit of pc_next is dropped.
    assign pc_d      = {pc_next[15:1], 1'b0};
    assign imem_addr = pc_curr;

    pc_reg u_pc_reg (
        .clk (clk),
        .rst (rst),
        .we  (pc_we),
        .d   (pc_d),
        .q   (pc_curr)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; inputs are ignored outside their state.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        pc_we       = 1'b0;
        latch_en    = 1'b0;
        count_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    latch_en   = 1'b1;
                    state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (is_hlt(instr)) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_we      = 1'b1;
                        count_en   = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction latch: captures the memory word on the fetch handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= 16'h0000;
        end else if (latch_en) begin
            instr <= imem_data;
        end
    end

    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= 16'h0000;
        end else if (count_en) begin
            instr_count <= instr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: drivers push expected {pc, instr, count} per
// fetched word; a negedge monitor pops and compares on each accept handshake.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] pc_next;
    logic        instr_ready;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc_curr;
    logic [15:0] instr;
    logic        instr_valid;
    logic        halted;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_q[$];
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_count;

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_next     (pc_next),
        .instr_ready (instr_ready),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc_curr     (pc_curr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted),
        .instr_count (instr_count)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accept handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL accept_unexpected: pc %h instr %h with empty queue", pc_curr, instr);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({pc_curr, instr, instr_count} !== e) begin
                    n_errors++;
                    $display("FAIL accept: got pc %h instr %h count %h expected pc %h instr %h count %h",
                             pc_curr, instr, instr_count, e[47:32], e[31:16], e[15:0]);
                end
            end
        end
    end

    // Check all outputs against reset values (called while reset state is expected).
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},    {15'd0, imem_req}, 16'd0);
        chk({tag, "_valid"},  {15'd0, instr_valid}, 16'd0);
        chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
        chk({tag, "_pc"},     pc_curr, 16'h0000);
        chk({tag, "_addr"},   imem_addr, 16'h0000);
        chk({tag, "_instr"},  instr, 16'h0000);
        chk({tag, "_count"},  instr_count, 16'h0000);
    endtask

    // Driver: starts in a FETCH cycle, stalls for `waits` cycles, then returns data.
    task automatic fetch_serve(input int waits, input logic [15:0] data);
        for (int w = 0; w < waits; w++) begin
            imem_rdy  = 1'b0;
            imem_data = 16'($urandom);
            @(negedge clk);
            chk("wait_req",  {15'd0, imem_req}, 16'd1);
            chk("wait_addr", imem_addr, exp_pc);
            step();
        end
        imem_rdy  = 1'b1;
        imem_data = data;
        @(negedge clk);
        chk("fetch_req",  {15'd0, imem_req}, 16'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        chk("fetch_nvalid", {15'd0, instr_valid}, 16'd0);
        exp_instr = data;
        exp_q.push_back({exp_pc, data, exp_count});
        step();
        imem_rdy  = 1'b0;
        imem_data = 16'($urandom);
    endtask

    // Driver: starts in a VALID cycle, back-pressures `holds` cycles, then accepts.
    task automatic accept(input int holds, input logic [15:0] nxt);
        for (int h = 0; h < holds; h++) begin
            instr_ready = 1'b0;
            pc_next     = 16'($urandom);
            imem_rdy    = h[0];
            imem_data   = 16'hBEEF;
            @(negedge clk);
            chk("hold_valid", {15'd0, instr_valid}, 16'd1);
            chk("hold_nreq",  {15'd0, imem_req}, 16'd0);
            chk("hold_pc",    pc_curr, exp_pc);
            chk("hold_instr", instr, exp_instr);
            step();
        end
        imem_rdy    = 1'b0;
        instr_ready = 1'b1;
        pc_next     = nxt;
        step();
        instr_ready = 1'b0;
        if (exp_instr[15:12] != 4'hF) begin
            exp_pc    = {nxt[15:1], 1'b0};
            exp_count = exp_count + 16'd1;
        end
        chk("post_pc",     pc_curr, exp_pc);
        chk("post_count",  instr_count, exp_count);
        chk("post_nvalid", {15'd0, instr_valid}, 16'd0);
    endtask

    // Apply reset for a few cycles with a memory response present, then release.
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        imem_rdy  = 1'b1;
        imem_data = 16'hDEAD;
        @(negedge clk);
        chk_reset_vals(tag);
        step();
        step();
        @(negedge clk);
        chk_reset_vals({tag, "_hold"});
        step();
        rst       = 1'b0;
        imem_rdy  = 1'b0;
        exp_pc    = 16'h0000;
        exp_count = 16'h0000;
        exp_instr = 16'h0000;
        // First cycle after release is IDLE.
        @(negedge clk);
        chk({tag, "_idle_req"},   {15'd0, imem_req}, 16'd0);
        chk({tag, "_idle_valid"}, {15'd0, instr_valid}, 16'd0);
        step();
    endtask

    // Main stimulus sequence.
    initial begin
        rst         = 1'b1;
        pc_next     = 16'h0000;
        instr_ready = 1'b0;
        imem_rdy    = 1'b0;
        imem_data   = 16'h0000;
        exp_pc      = 16'h0000;
        exp_count   = 16'h0000;
        exp_instr   = 16'h0000;
        step();

        do_reset("rst0");

        // Zero-wait first fetch at cycle 2, valid at cycle 3, then 5-cycle backpressure.
        fetch_serve(0, 16'h1234);
        accept(5, 16'h0041);

        // Wait states, odd pc_next, wrap to zero, plain accept.
        fetch_serve(3, 16'h2345);
        accept(0, 16'h1235);
        fetch_serve(1, 16'hA1FF);
        accept(2, 16'hFFFF);
        chk("wrap_pre_pc", pc_curr, 16'hFFFE);
        fetch_serve(0, 16'h7000);
        accept(0, 16'h0000);
        chk("wrap_addr", imem_addr, 16'h0000);
        fetch_serve(2, 16'h5555);
        accept(1, 16'h0101);

        // HLT retires without advancing PC or count; fetch stays stopped.
        fetch_serve(0, 16'hF000);
        accept(3, 16'h3333);
        for (int c = 0; c < 20; c++) begin
            imem_rdy    = c[0];
            instr_ready = 1'b1;
            pc_next     = 16'($urandom);
            @(negedge clk);
            chk("halt_req",    {15'd0, imem_req}, 16'd0);
            chk("halt_flag",   {15'd0, halted}, 16'd1);
            chk("halt_nvalid", {15'd0, instr_valid}, 16'd0);
            step();
        end
        instr_ready = 1'b0;
        imem_rdy    = 1'b0;
        chk("halt_pc",    pc_curr, 16'h0100);
        chk("halt_count", instr_count, 16'd5);

        // Leave HALT via reset, then abort a fetch with a coincident memory response.
        do_reset("rst1");
        imem_rdy  = 1'b1;
        imem_data = 16'hCAFE;
        rst       = 1'b1;
        @(negedge clk);
        chk_reset_vals("midfetch");
        exp_q.delete();
        step();
        do_reset("rst2");
        fetch_serve(0, 16'h0C0D);
        accept(1, 16'h0002);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
